harvard_sequencer: RTL
======================

// Module: harvard_sequencer
// PURPOSE
//  Multi-cycle controller for the Harvard MIPS core. Steps each instruction through
//  FETCH, DECODE, EXEC, optional MEM and optional WB. Drives the decode stage enable and
//  the execute, memory and writeback strobes, and owns the PC register.
//  Uses the decode stage's registered mem_active/reg_active flags to choose which optional stages run.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC value loaded on reset
//  HALT_PC       32'h00000000  PC value that stops the core when reached at FETCH
// PORTS
//  clk              in   1   core clock; all state changes on the rising edge
//  reset            in   1   synchronous, active-high
//  instr_valid      in   1   instruction memory data for pc is valid this cycle
//  mem_active       in   1   decode flag: current instruction accesses data memory
//  reg_active       in   1   decode flag: current instruction writes the register file
//  data_waitrequest in   1   data memory stall; 1 = access not complete
//  pc_next          in   32  next PC computed by the datapath (valid in EXEC and later)
//  pc               out  32  current instruction address
//  active           out  1   1 while running; 0 once halted
//  fetch_en         out  1   1 in FETCH
//  decode_en        out  1   1 for exactly one cycle, in DECODE
//  exec_en          out  1   1 for exactly one cycle, in EXEC
//  mem_req          out  1   1 throughout MEM
//  wb_en            out  1   1 for exactly one cycle, in WB
//  retired          out  32  count of completed instructions
//  state            out  3   debug: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALTED=5
// BEHAVIOUR
//  Reset (sampled on clk edge): state=FETCH, pc=RESET_VECTOR, retired=0, active=1.
//   Result: fetch_en=1 and all other strobes 0. Reset overrides every state, including
//   a MEM stall or HALTED. Strobes are pure Moore decodes of state.
//  FETCH: if pc==HALT_PC -> HALTED. Else, if instr_valid=1 -> DECODE; otherwise hold.
//   The halt check takes priority over instr_valid.
//  DECODE: always -> EXEC next cycle. The decode stage registers its flags on this edge.
//  EXEC: latch m=mem_active, r=reg_active into internal regs.
//   m=1 -> MEM; else r=1 -> WB; else complete.
//  MEM: hold while data_waitrequest=1, with no timeout. On the first cycle it is 0:
//   r(latched)=1 -> WB, else complete. Flag changes during MEM are ignored.
//  WB: always complete.
//  complete = on that edge: pc<=pc_next, retired<=retired+1 (wraps 2^32-1 -> 0), state<=FETCH.
//  Minimum latencies: 3 cycles (no MEM/WB), 4 (WB only), 4+stall cycles (MEM without WB),
//   5+stall cycles (MEM+WB).
//  HALTED: terminal. active=0, all strobes 0, pc and retired frozen. Only reset leaves.
//  pc_next is sampled only on a complete edge; its value at other times is don't-care.
//  No output is X after the first reset edge. Illegal state encodings (6,7) -> HALTED.
// TESTING
//  ALU op: m=0,r=1, instr_valid=1 -> states 0,1,2,4,0; wb_en 1 cycle; pc<=pc_next; retired=1.
//  Load, 3-cycle waitrequest: m=1,r=1 -> mem_req high 4 cycles, then WB, then FETCH.
//   Total 8 cycles; retired increments once.
//  Store: m=1,r=0, waitrequest=0 -> MEM 1 cycle then FETCH; wb_en never asserts.
//  Branch: m=0,r=0, pc_next=32'h00000000 -> complete from EXEC.
//   Next FETCH goes to HALTED: active=0, pc=0, strobes 0 for 20+ cycles.
//  instr_valid held 0 for 5 cycles in FETCH -> fetch_en stays 1, pc stable, no DECODE.
//  Reset asserted mid-MEM stall -> next edge: state=0, pc=BFC00000, retired=0, mem_req=0.

Source files
------------

// File: rtl/harvard_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the Harvard MIPS core.
// Owns the PC and the retired-instruction counter; strobes are Moore decodes of state.
module harvard_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_PC      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        mem_active,
  input  logic        reg_active,
  input  logic        data_waitrequest,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        active,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_req,
  output logic        wb_en,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   complete;
  logic   mem_flag;
  logic   reg_flag;

  // Next-state logic; complete marks the edge that retires the instruction.
  always_comb begin
    next_state = cur_state;
    complete   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (pc == HALT_PC) begin
          next_state = S_HALTED;
        end else if (instr_valid) begin
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (mem_active) begin
          next_state = S_MEM;
        end else if (reg_active) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;
          complete   = 1'b1;
        end
      end
      S_MEM: begin
        // Only the flags latched in EXEC steer the exit from MEM.
        if (data_waitrequest) begin
          next_state = S_MEM;
        end else if (reg_flag) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;
          complete   = 1'b1;
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        complete   = 1'b1;
      end
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_HALTED;
    endcase
  end

  // State, PC, retire counter and latched decode flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      pc        <= RESET_VECTOR;
      retired   <= 32'd0;
      mem_flag  <= 1'b0;
      reg_flag  <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (complete) begin
        pc      <= pc_next;
        retired <= retired + 32'd1;
      end else begin
        pc      <= pc;
        retired <= retired;
      end
      if (cur_state == S_EXEC) begin
        mem_flag <= mem_active;
        reg_flag <= reg_active;
      end else begin
        mem_flag <= mem_flag;
        reg_flag <= reg_flag;
      end
    end
  end

  // Moore output decode; any non-running encoding reads as halted.
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_req   = 1'b0;
    wb_en     = 1'b0;
    active    = 1'b1;
    case (cur_state)
      S_FETCH:  fetch_en  = 1'b1;
      S_DECODE: decode_en = 1'b1;
      S_EXEC:   exec_en   = 1'b1;
      S_MEM:    mem_req   = 1'b1;
      S_WB:     wb_en     = 1'b1;
      S_HALTED: active    = 1'b0;
      default:  active    = 1'b0;
    endcase
  end

  assign state = cur_state;

endmodule
